// File: rtl/sikep434_ise_pkg.sv
// Shared definitions for the SIKEp434 sigma ISE datapath and its issue scheduler.
package sikep434_ise_pkg;

    localparam int XLEN = 64;

    // ise_fn[1:0] custom-opcode encodings
    localparam logic [1:0] CUSTOM_0 = 2'b00;
    localparam logic [1:0] CUSTOM_1 = 2'b01;
    localparam logic [1:0] CUSTOM_2 = 2'b10;
    localparam logic [1:0] CUSTOM_3 = 2'b11;

    localparam logic [1:0] FUNCT_SIGMA = 2'b10;

    typedef struct packed {
        logic [4:0]      fn;
        logic [6:0]      imm;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
    } req_t;

    typedef struct packed {
        logic            err;
        logic [XLEN-1:0] out;
    } rsp_t;

endpackage

// File: rtl/xalu_ise_rspbuf.sv
// One-entry valid/ready response holding register; a load in the same cycle as a
// drain replaces the entry without a bubble.
module xalu_ise_rspbuf
    import sikep434_ise_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            load_err_i,
    input  logic [XLEN-1:0] load_out_i,
    input  logic            rdy_i,
    output logic            val_o,
    output logic            err_o,
    output logic [XLEN-1:0] out_o
);

    logic val_q, val_d;
    rsp_t data_q, data_d;

    always_comb begin
        val_d  = val_q;
        data_d = data_q;
        if (load_i) begin
            val_d      = 1'b1;
            data_d.err = load_err_i;
            data_d.out = load_out_i;
        end else if (rdy_i) begin
            // data is left in place on drain; only the valid flag drops
            val_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            val_q  <= 1'b0;
            data_q <= '0;
        end else begin
            val_q  <= val_d;
            data_q <= data_d;
        end
    end

    assign val_o = val_q;
    assign err_o = data_q.err;
    assign out_o = data_q.out;

endmodule

// File: rtl/xalu_ise_sched.sv
// Two-requester issue scheduler for the single-cycle xalu_ise datapath: arbitrates,
// drives the operand bus and buffers one result per requester.
module xalu_ise_sched #(
    parameter int XLEN  = sikep434_ise_pkg::XLEN,
    parameter bit RR_EN = 1'b1
) (
    input  logic            ise_clk,
    input  logic            ise_rst,
    input  logic            req0_val,
    output logic            req0_rdy,
    input  logic [4:0]      req0_fn,
    input  logic [6:0]      req0_imm,
    input  logic [XLEN-1:0] req0_in1,
    input  logic [XLEN-1:0] req0_in2,
    input  logic            req1_val,
    output logic            req1_rdy,
    input  logic [4:0]      req1_fn,
    input  logic [6:0]      req1_imm,
    input  logic [XLEN-1:0] req1_in1,
    input  logic [XLEN-1:0] req1_in2,
    output logic            rsp0_val,
    input  logic            rsp0_rdy,
    output logic [XLEN-1:0] rsp0_out,
    output logic            rsp0_err,
    output logic            rsp1_val,
    input  logic            rsp1_rdy,
    output logic [XLEN-1:0] rsp1_out,
    output logic            rsp1_err,
    output logic            alu_val,
    output logic [4:0]      alu_fn,
    output logic [6:0]      alu_imm,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    input  logic            alu_oval,
    input  logic [XLEN-1:0] alu_out
);

    import sikep434_ise_pkg::*;

    req_t req0_s, req1_s, sel_s;
    rsp_t cap_s;
    logic full0, full1, elig0, elig1, g0, g1;
    logic last_q, last_d;

    assign req0_s = '{fn: req0_fn, imm: req0_imm, in1: req0_in1, in2: req0_in2};
    assign req1_s = '{fn: req1_fn, imm: req1_imm, in1: req1_in1, in2: req1_in2};

    always_comb begin
        // a full buffer being drained this cycle may be refilled this cycle
        elig0 = ~ise_rst & req0_val & (~full0 | rsp0_rdy);
        elig1 = ~ise_rst & req1_val & (~full1 | rsp1_rdy);
        // last_q == 1 means requester 1 went last, so requester 0 wins a tie
        g0 = elig0 & (~elig1 | ~RR_EN | last_q);
        g1 = elig1 & ~g0;

        last_d = last_q;
        if (g0)      last_d = 1'b0;
        else if (g1) last_d = 1'b1;

        sel_s = '0;
        if (g0)      sel_s = req0_s;
        else if (g1) sel_s = req1_s;

        cap_s.err = ~alu_oval;
        cap_s.out = alu_oval ? alu_out : '0;
    end

    always_ff @(posedge ise_clk) begin
        if (ise_rst) last_q <= 1'b1;
        else         last_q <= last_d;
    end

    assign req0_rdy = g0;
    assign req1_rdy = g1;
    assign alu_val  = g0 | g1;
    assign alu_fn   = sel_s.fn;
    assign alu_imm  = sel_s.imm;
    assign alu_in1  = sel_s.in1;
    assign alu_in2  = sel_s.in2;

    xalu_ise_rspbuf u_buf0 (
        .clk_i      (ise_clk),
        .rst_i      (ise_rst),
        .load_i     (g0),
        .load_err_i (cap_s.err),
        .load_out_i (cap_s.out),
        .rdy_i      (rsp0_rdy),
        .val_o      (full0),
        .err_o      (rsp0_err),
        .out_o      (rsp0_out)
    );

    xalu_ise_rspbuf u_buf1 (
        .clk_i      (ise_clk),
        .rst_i      (ise_rst),
        .load_i     (g1),
        .load_err_i (cap_s.err),
        .load_out_i (cap_s.out),
        .rdy_i      (rsp1_rdy),
        .val_o      (full1),
        .err_o      (rsp1_err),
        .out_o      (rsp1_out)
    );

    assign rsp0_val = full0;
    assign rsp1_val = full1;

endmodule

// File: tb/tb_xalu_ise_sched.sv
// Directed bench for xalu_ise_sched: a round-robin and a fixed-priority instance share stimulus.
module tb_xalu_ise_sched;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_val, req1_val, rsp0_rdy, rsp1_rdy;
    logic [4:0]      req0_fn, req1_fn;
    logic [6:0]      req0_imm, req1_imm;
    logic [XLEN-1:0] req0_in1, req0_in2, req1_in1, req1_in2;

    logic            a_req0_rdy, a_req1_rdy, a_rsp0_val, a_rsp1_val, a_rsp0_err, a_rsp1_err;
    logic [XLEN-1:0] a_rsp0_out, a_rsp1_out;
    logic            a_alu_val, a_alu_oval;
    logic [4:0]      a_alu_fn;
    logic [6:0]      a_alu_imm;
    logic [XLEN-1:0] a_alu_in1, a_alu_in2, a_alu_out;

    logic            b_req0_rdy, b_req1_rdy, b_rsp0_val, b_rsp1_val, b_rsp0_err, b_rsp1_err;
    logic [XLEN-1:0] b_rsp0_out, b_rsp1_out;
    logic            b_alu_val, b_alu_oval;
    logic [4:0]      b_alu_fn;
    logic [6:0]      b_alu_imm;
    logic [XLEN-1:0] b_alu_in1, b_alu_in2, b_alu_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // datapath stand-in: fn==0 unsupported, otherwise in1 ^ in2 ^ 0x1236
    always_comb begin
        a_alu_oval = (a_alu_fn != 5'd0);
        a_alu_out  = a_alu_oval ? (a_alu_in1 ^ a_alu_in2 ^ 64'h1236) : 64'hFFFF;
        b_alu_oval = (b_alu_fn != 5'd0);
        b_alu_out  = b_alu_oval ? (b_alu_in1 ^ b_alu_in2 ^ 64'h1236) : 64'hFFFF;
    end

    xalu_ise_sched #(.XLEN(XLEN), .RR_EN(1'b1)) u_rr (
        .ise_clk(clk), .ise_rst(rst),
        .req0_val(req0_val), .req0_rdy(a_req0_rdy), .req0_fn(req0_fn), .req0_imm(req0_imm),
        .req0_in1(req0_in1), .req0_in2(req0_in2),
        .req1_val(req1_val), .req1_rdy(a_req1_rdy), .req1_fn(req1_fn), .req1_imm(req1_imm),
        .req1_in1(req1_in1), .req1_in2(req1_in2),
        .rsp0_val(a_rsp0_val), .rsp0_rdy(rsp0_rdy), .rsp0_out(a_rsp0_out), .rsp0_err(a_rsp0_err),
        .rsp1_val(a_rsp1_val), .rsp1_rdy(rsp1_rdy), .rsp1_out(a_rsp1_out), .rsp1_err(a_rsp1_err),
        .alu_val(a_alu_val), .alu_fn(a_alu_fn), .alu_imm(a_alu_imm), .alu_in1(a_alu_in1),
        .alu_in2(a_alu_in2), .alu_oval(a_alu_oval), .alu_out(a_alu_out)
    );

    xalu_ise_sched #(.XLEN(XLEN), .RR_EN(1'b0)) u_fp (
        .ise_clk(clk), .ise_rst(rst),
        .req0_val(req0_val), .req0_rdy(b_req0_rdy), .req0_fn(req0_fn), .req0_imm(req0_imm),
        .req0_in1(req0_in1), .req0_in2(req0_in2),
        .req1_val(req1_val), .req1_rdy(b_req1_rdy), .req1_fn(req1_fn), .req1_imm(req1_imm),
        .req1_in1(req1_in1), .req1_in2(req1_in2),
        .rsp0_val(b_rsp0_val), .rsp0_rdy(rsp0_rdy), .rsp0_out(b_rsp0_out), .rsp0_err(b_rsp0_err),
        .rsp1_val(b_rsp1_val), .rsp1_rdy(rsp1_rdy), .rsp1_out(b_rsp1_out), .rsp1_err(b_rsp1_err),
        .alu_val(b_alu_val), .alu_fn(b_alu_fn), .alu_imm(b_alu_imm), .alu_in1(b_alu_in1),
        .alu_in2(b_alu_in2), .alu_oval(b_alu_oval), .alu_out(b_alu_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        req0_val = 1'b0; req0_fn = '0; req0_imm = '0; req0_in1 = '0; req0_in2 = '0;
        req1_val = 1'b0; req1_fn = '0; req1_imm = '0; req1_in1 = '0; req1_in2 = '0;
        rsp0_rdy = 1'b0; rsp1_rdy = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_rsp0_val", 64'(a_rsp0_val), 64'd0);
        chk("rst_rsp1_val", 64'(a_rsp1_val), 64'd0);
        chk("rst_rsp0_out", a_rsp0_out, 64'd0);
        chk("rst_rsp1_err", 64'(a_rsp1_err), 64'd0);
        chk("rst_alu_val", 64'(a_alu_val), 64'd0);

        // request during reset is refused and not captured
        req0_val = 1'b1; req0_fn = 5'h01; req0_imm = 7'h43; req0_in1 = 64'h5; req0_in2 = 64'h7;
        settle();
        chk("rst_req0_rdy", 64'(a_req0_rdy), 64'd0);
        chk("rst_alu_val_req", 64'(a_alu_val), 64'd0);
        tick();
        chk("rst_nocapture", 64'(a_rsp0_val), 64'd0);

        // single op on requester 0
        rst = 1'b0;
        settle();
        chk("single_req0_rdy", 64'(a_req0_rdy), 64'd1);
        chk("single_alu_in1", a_alu_in1, 64'h5);
        chk("single_alu_imm", 64'(a_alu_imm), 64'h43);
        tick();
        req0_val = 1'b0;
        chk("single_rsp0_val", 64'(a_rsp0_val), 64'd1);
        chk("single_rsp0_out", a_rsp0_out, 64'h1234);
        chk("single_rsp0_err", 64'(a_rsp0_err), 64'd0);

        // backpressure: full buffer blocks requester 0
        req0_val = 1'b1; req0_in1 = 64'h8; req0_in2 = 64'h0;
        settle();
        chk("bp_req0_rdy", 64'(a_req0_rdy), 64'd0);
        chk("bp_alu_in1_idle", a_alu_in1, 64'd0);
        tick();
        chk("bp_hold_val", 64'(a_rsp0_val), 64'd1);
        chk("bp_hold_out", a_rsp0_out, 64'h1234);

        // drain and regrant in the same cycle
        rsp0_rdy = 1'b1;
        settle();
        chk("bp_regrant_rdy", 64'(a_req0_rdy), 64'd1);
        tick();
        req0_val = 1'b0;
        chk("bp_new_val", 64'(a_rsp0_val), 64'd1);
        chk("bp_new_out", a_rsp0_out, 64'h123E);
        tick();
        chk("drain_val", 64'(a_rsp0_val), 64'd0);
        chk("drain_out_kept", a_rsp0_out, 64'h123E);

        // unsupported op on requester 1
        req1_val = 1'b1; req1_fn = 5'h00; req1_imm = 7'h43; req1_in1 = 64'h1; req1_in2 = 64'h2;
        settle();
        chk("unsup_req1_rdy", 64'(a_req1_rdy), 64'd1);
        tick();
        req1_val = 1'b0;
        chk("unsup_rsp1_val", 64'(a_rsp1_val), 64'd1);
        chk("unsup_rsp1_err", 64'(a_rsp1_err), 64'd1);
        chk("unsup_rsp1_out", a_rsp1_out, 64'd0);

        // contention from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp0_rdy = 1'b1; rsp1_rdy = 1'b1;
        req0_val = 1'b1; req0_fn = 5'h01; req0_in1 = 64'h10; req0_in2 = 64'h0;
        req1_val = 1'b1; req1_fn = 5'h02; req1_in1 = 64'h20; req1_in2 = 64'h0;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk($sformatf("rr_req0_rdy_c%0d", c), 64'(a_req0_rdy), (c % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("rr_req1_rdy_c%0d", c), 64'(a_req1_rdy), (c % 2 == 0) ? 64'd0 : 64'd1);
            chk($sformatf("fp_req0_rdy_c%0d", c), 64'(b_req0_rdy), 64'd1);
            chk($sformatf("fp_req1_rdy_c%0d", c), 64'(b_req1_rdy), 64'd0);
            tick();
        end
        req0_val = 1'b0; req1_val = 1'b0;
        chk("rr_rsp1_out", a_rsp1_out, 64'h1216);
        chk("rr_rsp1_val", 64'(a_rsp1_val), 64'd1);
        chk("rr_rsp0_drained", 64'(a_rsp0_val), 64'd0);
        chk("fp_rsp0_out", b_rsp0_out, 64'h1226);
        chk("fp_rsp1_val", 64'(b_rsp1_val), 64'd0);

        // reset while a result is buffered
        rsp0_rdy = 1'b0; rsp1_rdy = 1'b0;
        req0_val = 1'b1; req0_fn = 5'h01; req0_in1 = 64'h5; req0_in2 = 64'h7;
        tick();
        req0_val = 1'b0;
        chk("mid_rsp0_val", 64'(a_rsp0_val), 64'd1);
        chk("mid_rsp0_out", a_rsp0_out, 64'h1234);
        rst = 1'b1; rsp0_rdy = 1'b1; req0_val = 1'b1;
        settle();
        chk("mid_rst_req0_rdy", 64'(a_req0_rdy), 64'd0);
        tick();
        chk("mid_rsp0_val_clr", 64'(a_rsp0_val), 64'd0);
        chk("mid_rsp0_out_clr", a_rsp0_out, 64'd0);
        rst = 1'b0; rsp1_rdy = 1'b1; req1_val = 1'b1;
        settle();
        chk("mid_first_req0", 64'(a_req0_rdy), 64'd1);
        chk("mid_first_req1", 64'(a_req1_rdy), 64'd0);
        tick();
        req0_val = 1'b0; req1_val = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
